// File: rtl/bat_reg_bank.sv
// ============================================================================
//  Module      : bat_reg_bank
//  Description : NREGS x WIDTH register bank with one bus write port, a
//                registered bus read port, two combinational ALU operand
//                ports, per-register inc/dec strobes and an OUT mirror.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bat_reg_bank #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 8,
  parameter int ADDR_W  = 3,
  parameter int OUT_IDX = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              HALT,
  input  logic              WR_EN,
  input  logic [ADDR_W-1:0] WR_SEL,
  input  logic [WIDTH-1:0]  WR_DATA,
  input  logic              RD_EN,
  input  logic [ADDR_W-1:0] RD_SEL,
  output logic [WIDTH-1:0]  RD_DATA,
  output logic              RD_VALID,
  input  logic [ADDR_W-1:0] SRC1_SEL,
  input  logic [ADDR_W-1:0] SRC2_SEL,
  output logic [WIDTH-1:0]  ALU_IN1,
  output logic [WIDTH-1:0]  ALU_IN2,
  input  logic [NREGS-1:0]  INC,
  input  logic [NREGS-1:0]  DEC,
  output logic [NREGS-1:0]  WRAP,
  output logic [WIDTH-1:0]  OUT,
  output logic              OUT_STROBE
);

  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic [NREGS-1:0] r_wrap;
  logic             r_out_strobe;

  logic [WIDTH-1:0] w_next [NREGS];
  logic [NREGS-1:0] w_wr_hit;
  logic [NREGS-1:0] w_wrap;
  logic [WIDTH-1:0] w_rd_val;
  logic [WIDTH-1:0] w_alu1;
  logic [WIDTH-1:0] w_alu2;

  // Per-register next state: write beats inc/dec; inc and dec together hold.
  // An index >= NREGS matches no register, so such a write is dropped.
  always_comb begin
    w_wr_hit = '0;
    w_wrap   = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_next[i]   = r_regs[i];
      w_wr_hit[i] = WR_EN && (WR_SEL == ADDR_W'(i));
      if (w_wr_hit[i]) begin
        w_next[i] = WR_DATA;
      end else if (INC[i] && !DEC[i]) begin
        w_next[i] = r_regs[i] + c_one;
        w_wrap[i] = &r_regs[i];
      end else if (DEC[i] && !INC[i]) begin
        w_next[i] = r_regs[i] - c_one;
        w_wrap[i] = ~|r_regs[i];
      end
    end
  end

  // Read returns the write-first next state; ALU ports see current contents.
  always_comb begin
    w_rd_val = '0;
    w_alu1   = '0;
    w_alu2   = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RD_SEL == ADDR_W'(i)) w_rd_val = w_next[i];
      if (SRC1_SEL == ADDR_W'(i)) w_alu1 = r_regs[i];
      if (SRC2_SEL == ADDR_W'(i)) w_alu2 = r_regs[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_wrap       <= '0;
      r_out_strobe <= 1'b0;
    end else if (HALT) begin
      r_rd_valid   <= 1'b0;
      r_wrap       <= '0;
      r_out_strobe <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= w_next[i];
      if (RD_EN) r_rd_data <= w_rd_val;
      r_rd_valid   <= RD_EN;
      r_wrap       <= w_wrap;
      r_out_strobe <= w_wr_hit[OUT_IDX];
    end
  end

  assign RD_DATA    = r_rd_data;
  assign RD_VALID   = r_rd_valid;
  assign WRAP       = r_wrap;
  assign OUT_STROBE = r_out_strobe;
  assign OUT        = r_regs[OUT_IDX];
  assign ALU_IN1    = w_alu1;
  assign ALU_IN2    = w_alu2;

endmodule

`default_nettype wire
